// File: rtl/ttl_251_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ttl_251_scan_ctrl
// Purpose  : Sequencer/arbiter for NCHIPS 74F251 muxes sharing one tristate
//            Y/W line. Break-before-make enable sequencing, background scan
//            into a status word, CPU single-bit reads with priority, and a
//            sticky W/Y consistency error flag.
// Revision : 1.0 - initial release
// ============================================================================
module ttl_251_scan_ctrl #(
    parameter int NCHIPS = 2,
    parameter int CW     = 1,
    parameter int GAP    = 1,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scan_en,
    input  logic                  rd_req,
    input  logic [CW+2:0]         rd_addr,
    output logic                  rd_ack,
    output logic                  rd_data,
    output logic                  sel_a,
    output logic                  sel_b,
    output logic                  sel_c,
    output logic [NCHIPS-1:0]     g_n,
    input  logic                  y_in,
    input  logic                  w_in,
    output logic [8*NCHIPS-1:0]   status,
    output logic                  status_valid,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int c_NBITS   = 8 * NCHIPS;
    localparam int c_AW      = CW + 3;
    localparam int c_CNT_MAX = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_AW-1:0]    c_LAST_IDX    = c_AW'(c_NBITS - 1);
    localparam logic [c_AW-1:0]    c_IDX_ONE     = c_AW'(1);
    localparam logic [CW:0]        c_NCHIPS      = (CW + 1)'(NCHIPS);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD    = c_CNT_W'(GAP - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_DRIVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_AW-1:0]      r_idx;
    logic [c_AW-1:0]      r_tgt;      // {chip, A, B, C} of the access in flight
    logic                 r_tgt_ok;   // target chip exists
    logic                 r_is_cpu;
    logic                 r_sample;
    logic [c_NBITS-1:0]   r_shadow;
    logic [c_NBITS-1:0]   r_status;
    logic [NCHIPS-1:0]    r_g_n;
    logic                 r_rd_ack;
    logic                 r_rd_data;
    logic                 r_status_valid;
    logic                 r_err;

    logic                 w_cpu_go;
    logic                 w_scan_go;
    logic [c_AW-1:0]      w_addr;
    logic                 w_addr_ok;
    logic [NCHIPS-1:0]    w_drive_n;
    logic [c_NBITS-1:0]   w_shadow_next;

    // Arbitration and target decode for the access about to be accepted.
    // A request still high during the ack cycle is the one just served, so
    // it is not re-accepted.
    always_comb begin
        w_cpu_go  = rd_req && !r_rd_ack;
        w_scan_go = scan_en && !w_cpu_go;
        w_addr    = w_cpu_go ? rd_addr : r_idx;
        w_addr_ok = ({1'b0, w_addr[c_AW-1:3]} < c_NCHIPS);
    end

    // One-hot active-low enable for the latched target; none for a bad chip.
    always_comb begin
        w_drive_n = '1;
        for (int i = 0; i < NCHIPS; i++) begin
            if (r_tgt_ok && (r_tgt[c_AW-1:3] == CW'(i))) begin
                w_drive_n[i] = 1'b0;
            end
        end
    end

    // Shadow word with the current sample merged in at the scan index.
    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = r_sample;
    end

    // Access sequencer: IDLE -> GAP -> DRIVE -> DONE -> IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_tgt          <= '0;
            r_tgt_ok       <= 1'b0;
            r_is_cpu       <= 1'b0;
            r_sample       <= 1'b0;
            r_shadow       <= '0;
            r_status       <= '0;
            r_g_n          <= '1;
            r_rd_ack       <= 1'b0;
            r_rd_data      <= 1'b0;
            r_status_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_rd_ack       <= 1'b0;
            r_status_valid <= 1'b0;
            // A detection later in this block overrides the clear.
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_g_n <= '1;
                    // Scan stopped: drop the partial scan, restart at bit 0.
                    if (!scan_en) begin
                        r_idx <= '0;
                    end
                    if (w_cpu_go || w_scan_go) begin
                        r_is_cpu <= w_cpu_go;
                        r_tgt    <= w_addr;
                        r_tgt_ok <= w_addr_ok;
                        r_cnt    <= c_GAP_LOAD;
                        r_state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_g_n   <= w_drive_n;
                        r_cnt   <= c_SETTLE_LOAD;
                        r_state <= S_DRIVE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == '0) begin
                        // Nothing drives the line for a non-existent chip, so
                        // the read returns 0 and the W/Y check is skipped.
                        r_sample <= r_tgt_ok & y_in;
                        if (r_tgt_ok && (w_in == y_in)) begin
                            r_err <= 1'b1;
                        end
                        r_g_n   <= '1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_g_n <= '1;
                    if (r_is_cpu) begin
                        r_rd_ack  <= 1'b1;
                        r_rd_data <= r_sample;
                    end else begin
                        r_shadow <= w_shadow_next;
                        if (r_idx == c_LAST_IDX) begin
                            r_status       <= w_shadow_next;
                            r_status_valid <= 1'b1;
                            r_idx          <= '0;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_g_n   <= '1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_ack       = r_rd_ack;
    assign rd_data      = r_rd_data;
    assign sel_a        = r_tgt[2];
    assign sel_b        = r_tgt[1];
    assign sel_c        = r_tgt[0];
    assign g_n          = r_g_n;
    assign status       = r_status;
    assign status_valid = r_status_valid;
    assign err          = r_err;

endmodule
`default_nettype wire
